alu_pipe_flags: RTL and testbench

//  Parametrised successor to the single-cycle ALU. It adds a valid/ready handshake on input and

---
 rtl/alu_pipe_flags_if.sv | 31 +++
 rtl/alu_pipe_flags.sv | 145 ++++++++++++++
 tb/tb_alu_pipe_flags.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pipe_flags_if.sv
// Operation/result handshake bundle between the operand stage, the ALU and writeback.
// master drives operations and out_ready; slave is the ALU.
interface alu_pipe_flags_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic             src2_shifted;
  logic             src2_carry;
  logic [3:0]       cmd;
  logic             mul;
  logic             set_flags;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             result_wr;
  logic [3:0]       nzcv;
  logic             busy;

  modport master (
    output in_valid, src1, src2, src2_shifted, src2_carry, cmd, mul, set_flags, out_ready,
    input  in_ready, out_valid, result, result_wr, nzcv, busy
  );

  modport slave (
    input  in_valid, src1, src2, src2_shifted, src2_carry, cmd, mul, set_flags, out_ready,
    output in_ready, out_valid, result, result_wr, nzcv, busy
  );
endinterface

// File: rtl/alu_pipe_flags.sv
// Handshaked ALU with a registered result stage, an owned NZCV register and an
// optional shift-add multiplier that retires one multiplier bit per cycle.
module alu_pipe_flags #(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input logic              CLOCK_50,
  input logic              RESET_N,
  alu_pipe_flags_if.slave  bus
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam int CW = $clog2(WIDTH + 1);

  logic [1:0]       state_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0] mplier_reg;
  logic             mul_set_reg;
  logic             out_valid_reg;
  logic             result_wr_reg;
  logic [WIDTH-1:0] result_reg;
  logic [3:0]       nzcv_reg;

  logic             accept;
  logic             is_mul;
  logic             is_cmp;
  logic             is_arith;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             c_in;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] logic_val;
  logic [WIDTH-1:0] alu_val;
  logic             alu_c;
  logic             alu_v;
  logic [3:0]       alu_flags;

  // The DONE cycle also blocks new operations: the multiply result owns the output stage next.
  assign bus.in_ready = (state_reg == ST_IDLE) && (!out_valid_reg || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign is_mul       = MUL_EN && bus.mul;
  assign is_cmp       = (bus.cmd[3:2] == 2'b10);

  // Every subtract form is an add of the inverted operand; carry-out is then NOT borrow.
  always_comb begin
    op_a     = bus.src1;
    op_b     = bus.src2;
    c_in     = 1'b0;
    is_arith = 1'b1;
    case (bus.cmd)
      4'h2, 4'hA: begin op_b = ~bus.src2; c_in = 1'b1; end
      4'h3:       begin op_a = bus.src2; op_b = ~bus.src1; c_in = 1'b1; end
      4'h4, 4'hB: c_in = 1'b0;
      4'h5:       c_in = nzcv_reg[1];
      4'h6:       begin op_b = ~bus.src2; c_in = nzcv_reg[1]; end
      4'h7:       begin op_a = bus.src2; op_b = ~bus.src1; c_in = nzcv_reg[1]; end
      default:    is_arith = 1'b0;
    endcase
  end

  always_comb begin
    logic_val = '0;
    case (bus.cmd)
      4'h0, 4'h8: logic_val = bus.src1 & bus.src2;
      4'h1, 4'h9: logic_val = bus.src1 ^ bus.src2;
      4'hC:       logic_val = bus.src1 | bus.src2;
      4'hD:       logic_val = bus.src2;
      4'hE:       logic_val = bus.src1 & ~bus.src2;
      4'hF:       logic_val = ~bus.src2;
      default:    logic_val = '0;
    endcase
  end

  assign sum       = {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, c_in};
  assign alu_val   = is_arith ? sum[WIDTH-1:0] : logic_val;
  assign alu_c     = is_arith ? sum[WIDTH]
                              : (bus.src2_shifted ? bus.src2_carry : nzcv_reg[1]);
  // Carry-in can never overflow operands of opposite sign, so the two-operand rule covers ADC/SBC/RSC.
  assign alu_v     = is_arith ? ((op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]))
                              : nzcv_reg[0];
  assign alu_flags = {alu_val[WIDTH-1], (alu_val == '0), alu_c, alu_v};

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      acc_reg       <= '0;
      mcand_reg     <= '0;
      mplier_reg    <= '0;
      mul_set_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
      result_wr_reg <= 1'b0;
      result_reg    <= '0;
      nzcv_reg      <= 4'b0000;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept && is_mul) begin
            state_reg     <= ST_MUL;
            cnt_reg       <= '0;
            acc_reg       <= '0;
            mcand_reg     <= bus.src1;
            mplier_reg    <= bus.src2;
            mul_set_reg   <= bus.set_flags;
            out_valid_reg <= 1'b0;
          end else if (accept) begin
            if (!is_cmp) result_reg <= alu_val;
            result_wr_reg <= !is_cmp;
            out_valid_reg <= 1'b1;
            if (bus.set_flags || is_cmp) nzcv_reg <= alu_flags;
          end else if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
          end
        end
        ST_MUL: begin
          if (mplier_reg[0]) acc_reg <= acc_reg + mcand_reg;
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
          cnt_reg    <= cnt_reg + CW'(1);
          if (cnt_reg == CW'(WIDTH - 1)) state_reg <= ST_DONE;
          if (bus.out_ready) out_valid_reg <= 1'b0;
        end
        ST_DONE: begin
          if (!out_valid_reg || bus.out_ready) begin
            result_reg    <= acc_reg;
            result_wr_reg <= 1'b1;
            out_valid_reg <= 1'b1;
            if (mul_set_reg) nzcv_reg[3:2] <= {acc_reg[WIDTH-1], (acc_reg == '0)};
            state_reg     <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.result    = result_reg;
  assign bus.result_wr = result_wr_reg;
  assign bus.nzcv      = nzcv_reg;
  assign bus.busy      = (state_reg == ST_MUL);
endmodule

// File: tb/tb_alu_pipe_flags.sv
// Bench for alu_pipe_flags: directed literal cases, then random traffic checked every
// cycle against a transaction-level reference model.
module tb_alu_pipe_flags;
  localparam int W = 32;

  logic CLOCK_50 = 1'b0;
  logic RESET_N  = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  alu_pipe_flags_if #(.WIDTH(W)) bus();

  alu_pipe_flags #(.WIDTH(W), .MUL_EN(1'b1)) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .bus      (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference ALU: plain wide integer arithmetic, signed range test for V.
  function automatic void alu_model(input bit [3:0] c, input bit [W-1:0] a, input bit [W-1:0] b,
                                    input bit s_bit, input bit shifted, input bit carry,
                                    input bit [3:0] f, output bit [W-1:0] val, output bit [3:0] fo);
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint bin = f[1] ? 64'sd0 : 64'sd1;
    longint u = 0;
    longint s = 0;
    bit arith = 1'b1;
    bit is_add = 1'b0;
    bit cf;
    bit vf;
    bit cmp = (c >= 4'h8) && (c <= 4'hB);
    case (c)
      4'h4, 4'hB: begin u = ua + ub;          s = sa + sb;          is_add = 1'b1; end
      4'h5:       begin u = ua + ub + (1-bin); s = sa + sb + (1-bin); is_add = 1'b1; end
      4'h2, 4'hA: begin u = ua - ub;          s = sa - sb;          end
      4'h6:       begin u = ua - ub - bin;    s = sa - sb - bin;    end
      4'h3:       begin u = ub - ua;          s = sb - sa;          end
      4'h7:       begin u = ub - ua - bin;    s = sb - sa - bin;    end
      default:    arith = 1'b0;
    endcase
    if (arith) begin
      val = u[W-1:0];
      cf  = is_add ? (u >= 64'sh1_0000_0000) : (u >= 0);
      vf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    end else begin
      case (c)
        4'h0, 4'h8: val = a & b;
        4'h1, 4'h9: val = a ^ b;
        4'hC:       val = a | b;
        4'hD:       val = b;
        4'hE:       val = a & ~b;
        default:    val = ~b;
      endcase
      cf = shifted ? carry : f[1];
      vf = f[0];
    end
    fo = (s_bit || cmp) ? {val[W-1], (val == 0), cf, vf} : f;
  endfunction

  // Model state: visible outputs plus the remaining cycles of an in-flight multiply.
  bit         m_ov;
  bit         m_wr;
  bit [W-1:0] m_res;
  bit [3:0]   m_nzcv;
  int         mul_left;
  bit [W-1:0] mul_prod;
  bit         mul_set;

  initial begin : monitor
    bit         exp_ready;
    bit         acc_now;
    bit [W-1:0] v;
    bit [3:0]   fo;
    m_ov = 0; m_wr = 0; m_res = 0; m_nzcv = 0; mul_left = 0; mul_prod = 0; mul_set = 0;
    forever begin
      @(negedge CLOCK_50);
      if (!RESET_N) begin
        m_ov = 0; m_wr = 0; m_res = 0; m_nzcv = 0; mul_left = 0;
      end
      exp_ready = (mul_left == 0) && (!m_ov || bus.out_ready);
      check("mon_out_valid", W'(bus.out_valid), W'(m_ov));
      check("mon_in_ready",  W'(bus.in_ready),  W'(exp_ready));
      check("mon_busy",      W'(bus.busy),      W'(mul_left > 1));
      check("mon_nzcv",      W'(bus.nzcv),      W'(m_nzcv));
      check("mon_result",    bus.result,        m_res);
      check("mon_result_wr", W'(bus.result_wr), W'(m_wr));
      if (RESET_N) begin
        acc_now = bus.in_valid && exp_ready;
        if (mul_left > 1) begin
          mul_left--;
          if (bus.out_ready) m_ov = 0;
        end else if (mul_left == 1) begin
          if (!m_ov || bus.out_ready) begin
            m_res = mul_prod; m_wr = 1; m_ov = 1; mul_left = 0;
            if (mul_set) begin m_nzcv[3] = mul_prod[W-1]; m_nzcv[2] = (mul_prod == 0); end
          end
        end else if (acc_now && bus.mul) begin
          mul_left = W + 1;
          mul_prod = bus.src1 * bus.src2;
          mul_set  = bus.set_flags;
          m_ov     = 0;
        end else if (acc_now) begin
          alu_model(bus.cmd, bus.src1, bus.src2, bus.set_flags, bus.src2_shifted,
                    bus.src2_carry, m_nzcv, v, fo);
          if (!(bus.cmd >= 4'h8 && bus.cmd <= 4'hB)) m_res = v;
          m_wr   = !(bus.cmd >= 4'h8 && bus.cmd <= 4'hB);
          m_nzcv = fo;
          m_ov   = 1;
        end else if (bus.out_ready) begin
          m_ov = 0;
        end
      end
    end
  end

  task automatic drive(input bit [3:0] c, input bit [W-1:0] a, input bit [W-1:0] b, input bit s,
                       input bit sh, input bit cy, input bit m);
    bus.in_valid = 1; bus.cmd = c; bus.src1 = a; bus.src2 = b; bus.set_flags = s;
    bus.src2_shifted = sh; bus.src2_carry = cy; bus.mul = m;
  endtask

  // Presents an op and returns at posedge+2 after the edge that accepted it.
  task automatic send(input bit [3:0] c, input bit [W-1:0] a, input bit [W-1:0] b, input bit s,
                      input bit sh, input bit cy, input bit m);
    bit ok = 0;
    drive(c, a, b, s, sh, cy, m);
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge CLOCK_50);
      ok = bus.in_ready;
    end
    tests++;
    if (!ok) begin fails++; $display("FAIL send_timeout: in_ready never rose for cmd %0h", c); end
    @(posedge CLOCK_50); #2;
    bus.in_valid = 0;
  endtask

  function automatic bit [W-1:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    bit [W-1:0] v;
    bit [3:0]   fo;
    bit         acc;
    bus.in_valid = 0; bus.src1 = 0; bus.src2 = 0; bus.src2_shifted = 0; bus.src2_carry = 0;
    bus.cmd = 0; bus.mul = 0; bus.set_flags = 0; bus.out_ready = 1;

    // Pin the model on the carry-in overflow and the borrow rule.
    alu_model(4'h5, 32'h7FFF_FFFF, 32'h0, 1'b1, 1'b0, 1'b0, 4'b0010, v, fo);
    check("model_adc_v", W'(fo), W'(4'b1001));
    alu_model(4'h6, 32'h5, 32'h5, 1'b1, 1'b0, 1'b0, 4'b0000, v, fo);
    check("model_sbc_borrow", v, 32'hFFFF_FFFF);

    @(posedge CLOCK_50); @(posedge CLOCK_50); #2;
    RESET_N = 1;
    #1;
    check("rst_out_valid", W'(bus.out_valid), 0);
    check("rst_result",    bus.result, 0);
    check("rst_result_wr", W'(bus.result_wr), 0);
    check("rst_nzcv",      W'(bus.nzcv), 0);
    check("rst_busy",      W'(bus.busy), 0);

    send(4'h4, 32'h7FFF_FFFF, 32'h1, 1, 0, 0, 0);
    check("t1_out_valid", W'(bus.out_valid), 1);
    check("t1_result",    bus.result, 32'h8000_0000);
    check("t1_nzcv",      W'(bus.nzcv), W'(4'b1001));

    send(4'hA, 32'h5, 32'h5, 0, 0, 0, 0);
    check("t2_cmp_nzcv", W'(bus.nzcv), W'(4'b0110));
    check("t2_cmp_wr",   W'(bus.result_wr), 0);
    send(4'h5, 32'h1, 32'h1, 1, 0, 0, 0);
    check("t2_adc_result", bus.result, 32'h3);
    check("t2_adc_nzcv",   W'(bus.nzcv), W'(4'b0000));

    send(4'h4, 32'h7FFF_FFFF, 32'h1, 1, 0, 0, 0);
    send(4'hD, 32'h0, 32'h0, 1, 1, 1, 0);
    check("t3_result", bus.result, 32'h0);
    check("t3_nzcv",   W'(bus.nzcv), W'(4'b0111));

    send(4'h0, 32'h0001_0003, 32'h0000_0010, 1, 0, 0, 1);
    for (int i = 0; i < W; i++) begin
      check("t4_busy", W'(bus.busy), 1);
      check("t4_in_ready", W'(bus.in_ready), 0);
      @(posedge CLOCK_50); #2;
    end
    check("t4_busy_end", W'(bus.busy), 0);
    @(posedge CLOCK_50); #2;
    check("t4_out_valid", W'(bus.out_valid), 1);
    check("t4_result",    bus.result, 32'h0010_0030);
    check("t4_nzcv",      W'(bus.nzcv), W'(4'b0011));

    @(posedge CLOCK_50); #2;
    check("t5_drained", W'(bus.out_valid), 0);
    bus.out_ready = 0;
    send(4'h4, 32'd10, 32'd20, 0, 0, 0, 0);
    drive(4'h4, 32'd1, 32'd1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      check("t5_hold_valid", W'(bus.out_valid), 1);
      check("t5_hold_result", bus.result, 32'd30);
      check("t5_hold_ready", W'(bus.in_ready), 0);
      @(posedge CLOCK_50); #2;
    end
    bus.out_ready = 1;
    @(posedge CLOCK_50); #2;
    bus.in_valid = 0;
    check("t5_swap_result", bus.result, 32'd2);
    @(posedge CLOCK_50); #2;
    check("t5_consumed", W'(bus.out_valid), 0);

    send(4'h0, 32'h1234_5678, 32'h9ABC_DEF1, 1, 0, 0, 1);
    repeat (10) @(posedge CLOCK_50);
    #3 RESET_N = 0;
    #1;
    check("t6_busy",      W'(bus.busy), 0);
    check("t6_out_valid", W'(bus.out_valid), 0);
    check("t6_nzcv",      W'(bus.nzcv), 0);
    @(posedge CLOCK_50); #2;
    RESET_N = 1;
    send(4'h4, 32'd2, 32'd3, 0, 0, 0, 0);
    check("t6_add_result", bus.result, 32'd5);
    repeat (W + 4) @(posedge CLOCK_50);
    #2;
    check("t6_no_mul_result", bus.result, 32'd5);

    for (int i = 0; i < 600; i++) begin
      @(negedge CLOCK_50); #1;
      acc = bus.in_valid && bus.in_ready;
      @(posedge CLOCK_50); #2;
      if (acc || !bus.in_valid) begin
        drive(4'($urandom_range(0, 15)), rand_operand(), rand_operand(), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
        bus.in_valid = ($urandom_range(0, 4) != 0);
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end
    bus.in_valid = 0;
    bus.out_ready = 1;
    repeat (W + 6) @(posedge CLOCK_50);
    #2;
    check("drain_idle", W'(bus.out_valid), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
